dll_lock_code_ctrl: RTL and testbench
=====================================

Name: dll_lock_code_ctrl

Overview:
Control-side partner of the DDR3 DLL wrapper. It drives DLL_POWERDOWN_N and DLL_CODE_UPDATE, and consumes DLL_LOCK, DLL_DELAY_DIFF and DLL_CODE. It sequences power-up, qualifies lock, and issues periodic or requested code-update pulses. It then captures a stable 8-bit delay code and presents it with READY/valid status to the DDR3 PHY training logic.

Parameters:
PD_CYCLES, 16, cycles DLL_POWERDOWN_N held low after reset or relock (min 2)
LOCK_FILTER, 8, consecutive synchronized-lock-high cycles required to qualify lock (min 1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before declaring timeout
UPDATE_PERIOD, 1024, cycles between automatic code updates while locked
UPDATE_PULSE, 4, width of the DLL_CODE_UPDATE pulse in cycles (min 1)

Ports:
CLK  in  1  system clock; all logic is on the rising edge
RESET_N  in  1  synchronous, active-low reset
DLL_LOCK  in  1  DLL lock, asynchronous to CLK; 2-flop synchronized internally (lock_s)
DLL_DELAY_DIFF  in  1  DLL delay-drift flag, asynchronous; 2-flop synchronized (diff_s)
DLL_CODE  in  8  DLL delay code; sampled only in the CAPTURE state
UPDATE_REQ  in  1  single-cycle request for an immediate code update
RELOCK_REQ  in  1  single-cycle request for a full power-down/relock
DLL_POWERDOWN_N  out  1  DLL power-down control, active-low, registered
DLL_CODE_UPDATE  out  1  DLL code-update strobe, registered
CODE_Q  out  8  last captured delay code
CODE_VALID  out  1  CODE_Q is valid for the current lock
READY  out  1  high only in state LOCKED
LOCK_LOST  out  1  sticky: lock dropped after qualification
TIMEOUT  out  1  sticky: lock not qualified within LOCK_TIMEOUT

Behaviour:
- Reset (RESET_N=0 at an edge): all outputs 0, including DLL_POWERDOWN_N=0. State=PWRDN, counters=0, sync flops=0, pending=0. Reset mid-operation aborts any pulse in progress on the next edge.
- Counter widths: each counter uses clog2 of its parameter plus 1 bit. Counters saturate and never wrap.
- PWRDN: DLL_POWERDOWN_N=0 for PD_CYCLES cycles. Then DLL_POWERDOWN_N goes 1 and the state goes to WAIT_LOCK, with the filter and timeout counters cleared.
- WAIT_LOCK:
  - The filter counter increments while lock_s=1 and clears on any lock_s=0.
  - When the filter reaches LOCK_FILTER, go to UPDATE.
  - A timeout counter increments every cycle. If it reaches LOCK_TIMEOUT first: set TIMEOUT, go to PWRDN (automatic retry).
- UPDATE: DLL_CODE_UPDATE=1 for exactly UPDATE_PULSE cycles, then 0. Go to SETTLE.
- SETTLE: 2 cycles with DLL_CODE_UPDATE=0, then CAPTURE.
- CAPTURE (1 cycle): register DLL_CODE into CODE_Q, set CODE_VALID=1, go to LOCKED. CODE_Q/CODE_VALID become visible on the first LOCKED cycle.
- LOCKED:
  - READY=1. The period counter restarts at 0 on every entry.
  - Go to UPDATE when any of these occurs: the period counter reaches UPDATE_PERIOD-1; UPDATE_REQ=1; pending=1; a rising edge of diff_s.
  - Latency: UPDATE_REQ at cycle t gives DLL_CODE_UPDATE=1 on cycles t+1..t+UPDATE_PULSE, and CODE_Q updated at t+UPDATE_PULSE+4.
- Pending requests: an UPDATE_REQ or diff_s rising edge during UPDATE/SETTLE/CAPTURE sets pending (1-deep; extra requests merge). Pending is cleared on entry to UPDATE.
- Lock loss: lock_s=0 in UPDATE, SETTLE, CAPTURE or LOCKED has the following effect:
  - LOCK_LOST=1, CODE_VALID=0, READY=0, DLL_CODE_UPDATE=0 next cycle.
  - Go to WAIT_LOCK; DLL_POWERDOWN_N stays 1.
  - The CAPTURE write is suppressed that cycle; CODE_Q keeps its old value.
- RELOCK_REQ in any state except PWRDN has the following effect:
  - Go to PWRDN: DLL_POWERDOWN_N=0, CODE_VALID=0, DLL_CODE_UPDATE=0.
  - Clears LOCK_LOST, TIMEOUT and pending.
  - RELOCK_REQ in PWRDN restarts the PD count.
- Priority for simultaneous events: RESET_N > RELOCK_REQ > lock loss > TIMEOUT > update triggers (all triggers merge into one update).
- LOCK_LOST and TIMEOUT clear only on reset or RELOCK_REQ.
- DLL_CODE_UPDATE is never high outside UPDATE. DLL_POWERDOWN_N is never low outside PWRDN.

Test Plan:
1. Release reset with DLL_LOCK=1 and DLL_CODE=0xA5. Required response:
   - DLL_POWERDOWN_N low for exactly 16 cycles.
   - DLL_CODE_UPDATE high for exactly 4 cycles.
   - CODE_Q=0xA5, CODE_VALID=1, READY=1, flags 0.
2. Hold DLL_LOCK=0 after release (LOCK_TIMEOUT=64 for bench speed). Required response:
   - TIMEOUT=1 after 64 WAIT_LOCK cycles.
   - DLL_POWERDOWN_N re-pulses low for 16 cycles.
   - Raising DLL_LOCK then reaches READY while TIMEOUT stays 1.
3. Locked, DLL_CODE changed to 0x3C:
   - Pulse UPDATE_REQ at t: DLL_CODE_UPDATE high t+1..t+4, CODE_Q=0x3C at t+8.
   - With no request, auto-update follows UPDATE_PERIOD cycles after LOCKED entry.
4. In WAIT_LOCK, glitch DLL_LOCK to 0 for 1 cycle at filter count 5: the filter restarts, and UPDATE starts only after 8 clean synchronized cycles.
5. Locked, drop DLL_LOCK during UPDATE. Required response:
   - DLL_CODE_UPDATE deasserts, LOCK_LOST=1, CODE_VALID=0, CODE_Q unchanged.
   - Relock gives READY with LOCK_LOST still 1. RELOCK_REQ clears it.
6. Assert UPDATE_REQ, a DLL_DELAY_DIFF rise and RELOCK_REQ in the same cycle: RELOCK wins (PWRDN, pending cleared). Separately, UPDATE_REQ during SETTLE produces exactly one extra update after LOCKED.

Source files
------------

// File: rtl/dll_lock_code_ctrl.sv
// DLL lock/code control: power-up sequencing, lock qualification, periodic or
// requested code-update pulses, and capture of the settled 8-bit delay code.
module dll_lock_code_ctrl #(
  parameter int unsigned PD_CYCLES     = 16,
  parameter int unsigned LOCK_FILTER   = 8,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned UPDATE_PERIOD = 1024,
  parameter int unsigned UPDATE_PULSE  = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       DLL_LOCK,
  input  logic       DLL_DELAY_DIFF,
  input  logic [7:0] DLL_CODE,
  input  logic       UPDATE_REQ,
  input  logic       RELOCK_REQ,
  output logic       DLL_POWERDOWN_N,
  output logic       DLL_CODE_UPDATE,
  output logic [7:0] CODE_Q,
  output logic       CODE_VALID,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic       TIMEOUT
);

  localparam int unsigned PD_W  = $clog2(PD_CYCLES) + 1;
  localparam int unsigned FLT_W = $clog2(LOCK_FILTER) + 1;
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned PER_W = $clog2(UPDATE_PERIOD) + 1;
  localparam int unsigned UP_W  = $clog2(UPDATE_PULSE) + 1;

  typedef enum logic [2:0] {
    PWRDN, WAIT_LOCK, UPDATE, SETTLE, CAPTURE, LOCKED
  } state_t;

  state_t state, state_n;

  logic [PD_W-1:0]  pd_cnt, pd_cnt_n;
  logic [FLT_W-1:0] filt_cnt, filt_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [PER_W-1:0] per_cnt, per_cnt_n;
  logic [UP_W-1:0]  up_cnt, up_cnt_n;
  logic             settle_cnt, settle_cnt_n;
  logic             pending, pending_n;
  logic [7:0]       code_q_n;
  logic             code_valid_n, lock_lost_n, timeout_n;
  logic             lock_s1, lock_s, diff_s1, diff_s, diff_d;
  logic             trig, diff_rise, in_lock_phase;

  assign diff_rise     = diff_s & ~diff_d;
  assign trig          = UPDATE_REQ | diff_rise;
  assign in_lock_phase = (state == UPDATE) || (state == SETTLE) ||
                         (state == CAPTURE) || (state == LOCKED);

  // State, counters, synchronizers and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state           <= PWRDN;
      pd_cnt          <= '0;
      filt_cnt        <= '0;
      to_cnt          <= '0;
      per_cnt         <= '0;
      up_cnt          <= '0;
      settle_cnt      <= 1'b0;
      pending         <= 1'b0;
      lock_s1         <= 1'b0;
      lock_s          <= 1'b0;
      diff_s1         <= 1'b0;
      diff_s          <= 1'b0;
      diff_d          <= 1'b0;
      DLL_POWERDOWN_N <= 1'b0;
      DLL_CODE_UPDATE <= 1'b0;
      CODE_Q          <= 8'h00;
      CODE_VALID      <= 1'b0;
      READY           <= 1'b0;
      LOCK_LOST       <= 1'b0;
      TIMEOUT         <= 1'b0;
    end else begin
      state           <= state_n;
      pd_cnt          <= pd_cnt_n;
      filt_cnt        <= filt_cnt_n;
      to_cnt          <= to_cnt_n;
      per_cnt         <= per_cnt_n;
      up_cnt          <= up_cnt_n;
      settle_cnt      <= settle_cnt_n;
      pending         <= pending_n;
      lock_s1         <= DLL_LOCK;
      lock_s          <= lock_s1;
      diff_s1         <= DLL_DELAY_DIFF;
      diff_s          <= diff_s1;
      diff_d          <= diff_s;
      DLL_POWERDOWN_N <= (state_n != PWRDN);
      DLL_CODE_UPDATE <= (state_n == UPDATE);
      CODE_Q          <= code_q_n;
      CODE_VALID      <= code_valid_n;
      READY           <= (state_n == LOCKED);
      LOCK_LOST       <= lock_lost_n;
      TIMEOUT         <= timeout_n;
    end
  end

  // Per-state counters idle at zero, so each state starts counting from 0 on entry
  always_comb begin
    state_n      = state;
    pd_cnt_n     = '0;
    filt_cnt_n   = '0;
    to_cnt_n     = '0;
    per_cnt_n    = '0;
    up_cnt_n     = '0;
    settle_cnt_n = 1'b0;
    pending_n    = pending;
    code_q_n     = CODE_Q;
    code_valid_n = CODE_VALID;
    lock_lost_n  = LOCK_LOST;
    timeout_n    = TIMEOUT;

    if (RELOCK_REQ) begin
      state_n = PWRDN;
      if (state != PWRDN) begin
        lock_lost_n  = 1'b0;
        timeout_n    = 1'b0;
        pending_n    = 1'b0;
        code_valid_n = 1'b0;
      end
    end else if (in_lock_phase && !lock_s) begin
      state_n      = WAIT_LOCK;
      lock_lost_n  = 1'b1;
      code_valid_n = 1'b0;
    end else begin
      case (state)
        PWRDN: begin
          if (pd_cnt == PD_W'(PD_CYCLES - 1)) state_n = WAIT_LOCK;
          else pd_cnt_n = pd_cnt + PD_W'(1);
        end
        WAIT_LOCK: begin
          if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            timeout_n = 1'b1;
            state_n   = PWRDN;
          end else begin
            to_cnt_n = to_cnt + TO_W'(1);
            if (lock_s) begin
              if (filt_cnt == FLT_W'(LOCK_FILTER - 1)) state_n = UPDATE;
              else filt_cnt_n = filt_cnt + FLT_W'(1);
            end
          end
        end
        UPDATE: begin
          if (trig) pending_n = 1'b1;
          if (up_cnt == UP_W'(UPDATE_PULSE - 1)) state_n = SETTLE;
          else up_cnt_n = up_cnt + UP_W'(1);
        end
        SETTLE: begin
          if (trig) pending_n = 1'b1;
          if (settle_cnt) state_n = CAPTURE;
          else settle_cnt_n = 1'b1;
        end
        CAPTURE: begin
          if (trig) pending_n = 1'b1;
          code_q_n     = DLL_CODE;
          code_valid_n = 1'b1;
          state_n      = LOCKED;
        end
        LOCKED: begin
          if (trig || pending || (per_cnt == PER_W'(UPDATE_PERIOD - 1))) state_n = UPDATE;
          else per_cnt_n = per_cnt + PER_W'(1);
        end
        default: state_n = PWRDN;
      endcase
    end

    if ((state_n == UPDATE) && (state != UPDATE)) pending_n = 1'b0;
  end

endmodule

// File: tb/tb_dll_lock_code_ctrl.sv
// Directed bench for dll_lock_code_ctrl; LOCK_TIMEOUT=64 and UPDATE_PERIOD=128 keep runs short.
module tb_dll_lock_code_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dll_lock;
  logic       dll_delay_diff;
  logic [7:0] dll_code;
  logic       update_req;
  logic       relock_req;
  logic       pd_n;
  logic       upd;
  logic [7:0] code_q;
  logic       code_valid;
  logic       ready;
  logic       lock_lost;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dll_lock_code_ctrl #(
    .PD_CYCLES(16), .LOCK_FILTER(8), .LOCK_TIMEOUT(64),
    .UPDATE_PERIOD(128), .UPDATE_PULSE(4)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .DLL_LOCK(dll_lock), .DLL_DELAY_DIFF(dll_delay_diff),
    .DLL_CODE(dll_code), .UPDATE_REQ(update_req), .RELOCK_REQ(relock_req),
    .DLL_POWERDOWN_N(pd_n), .DLL_CODE_UPDATE(upd), .CODE_Q(code_q),
    .CODE_VALID(code_valid), .READY(ready), .LOCK_LOST(lock_lost), .TIMEOUT(timeout)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic lock);
    rst_n = 1'b0; dll_lock = lock; dll_delay_diff = 1'b0;
    update_req = 1'b0; relock_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL wait_ready timed out ready=%b", ready); end
  endtask

  task automatic test_reset();
    int n;
    dll_code = 8'hA5;
    do_reset(1'b1);
    checks++;
    if ({pd_n, upd, code_q, code_valid, ready, lock_lost, timeout} !== 14'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0",
        {pd_n, upd, code_q, code_valid, ready, lock_lost, timeout});
    end
    rst_n = 1'b1;
    n = 0; while (pd_n === 1'b0 && n < 200) begin n++; tick(); end
    checks++; if (n != 16) begin failures++; $display("FAIL pd_low_cycles got=%0d exp=16", n); end
    n = 0; while (upd === 1'b0 && n < 200) begin n++; tick(); end
    checks++; if (n != 8) begin failures++; $display("FAIL wait_lock_cycles got=%0d exp=8", n); end
    n = 0; while (upd === 1'b1 && n < 200) begin n++; tick(); end
    checks++; if (n != 4) begin failures++; $display("FAIL update_pulse_width got=%0d exp=4", n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_in_settle got=%b exp=0", ready); end
    repeat (3) tick();
    checks++;
    if ({code_q, code_valid, ready, lock_lost, timeout} !== {8'hA5, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL first_lock got=%h exp=%h",
        {code_q, code_valid, ready, lock_lost, timeout}, {8'hA5, 4'b1100});
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset(1'b0);
    rst_n = 1'b1;
    n = 0; while (pd_n === 1'b0 && n < 200) begin n++; tick(); end
    n = 0; while (pd_n === 1'b1 && n < 200) begin n++; tick(); end
    checks++; if (n != 64) begin failures++; $display("FAIL timeout_cycles got=%0d exp=64", n); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", timeout); end
    dll_lock = 1'b1;
    n = 0; while (pd_n === 1'b0 && n < 200) begin n++; tick(); end
    checks++; if (n != 16) begin failures++; $display("FAIL retry_pd_cycles got=%0d exp=16", n); end
    wait_ready();
    checks++;
    if ({timeout, code_valid, code_q} !== {1'b1, 1'b1, 8'hA5}) begin
      failures++; $display("FAIL timeout_sticky got=%h exp=%h", {timeout, code_valid, code_q}, {2'b11, 8'hA5});
    end
  endtask

  task automatic test_update_req();
    int n;
    dll_code = 8'h3C;
    tick();
    update_req = 1'b1; tick(); update_req = 1'b0;
    n = 0; while (upd === 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (n != 4) begin failures++; $display("FAIL req_pulse_width got=%0d exp=4", n); end
    repeat (2) tick();
    checks++; if (code_q !== 8'hA5) begin failures++; $display("FAIL code_q_t7 got=%h exp=a5", code_q); end
    tick();
    checks++;
    if ({code_q, ready} !== {8'h3C, 1'b1}) begin
      failures++; $display("FAIL code_q_t8 got=%h exp=%h", {code_q, ready}, {8'h3C, 1'b1});
    end
    dll_code = 8'h5A;
    n = 0; while (upd === 1'b0 && n < 400) begin n++; tick(); end
    checks++; if (n != 128) begin failures++; $display("FAIL auto_update_period got=%0d exp=128", n); end
    wait_ready();
    checks++; if (code_q !== 8'h5A) begin failures++; $display("FAIL auto_capture got=%h exp=5a", code_q); end
  endtask

  task automatic test_filter_glitch();
    int n;
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    checks++;
    if ({timeout, pd_n, code_valid} !== 3'b000) begin
      failures++; $display("FAIL relock_clear got=%b exp=000", {timeout, pd_n, code_valid});
    end
    n = 0; while (pd_n === 1'b0 && n < 200) begin n++; tick(); end
    checks++; if (n != 16) begin failures++; $display("FAIL relock_pd_cycles got=%0d exp=16", n); end
    n = 0;
    while (upd === 1'b0 && pd_n === 1'b1 && n < 200) begin
      n++;
      dll_lock = (n == 4) ? 1'b0 : 1'b1;
      tick();
    end
    checks++; if (n != 14) begin failures++; $display("FAIL glitch_filter_cycles got=%0d exp=14", n); end
    wait_ready();
  endtask

  task automatic test_lock_loss();
    dll_code = 8'h77;
    update_req = 1'b1; tick(); update_req = 1'b0;
    dll_lock = 1'b0;
    repeat (2) tick();
    checks++; if (upd !== 1'b1) begin failures++; $display("FAIL upd_before_loss got=%b exp=1", upd); end
    tick();
    checks++;
    if ({upd, lock_lost, code_valid, ready, pd_n, code_q} !== {5'b01001, 8'h5A}) begin
      failures++; $display("FAIL lock_loss got=%h exp=%h",
        {upd, lock_lost, code_valid, ready, pd_n, code_q}, {5'b01001, 8'h5A});
    end
    repeat (10) tick();
    checks++;
    if ({code_q, code_valid} !== {8'h5A, 1'b0}) begin
      failures++; $display("FAIL no_capture_unlocked got=%h exp=%h", {code_q, code_valid}, {8'h5A, 1'b0});
    end
    dll_lock = 1'b1;
    wait_ready();
    checks++;
    if ({lock_lost, code_q} !== {1'b1, 8'h77}) begin
      failures++; $display("FAIL relock_sticky got=%h exp=%h", {lock_lost, code_q}, {1'b1, 8'h77});
    end
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    checks++;
    if ({lock_lost, pd_n} !== 2'b00) begin
      failures++; $display("FAIL relock_clears_lost got=%b exp=00", {lock_lost, pd_n});
    end
    wait_ready();
  endtask

  task automatic test_simultaneous();
    int n;
    update_req = 1'b1; tick(); update_req = 1'b0;
    tick();
    update_req = 1'b1; tick(); update_req = 1'b0;
    dll_delay_diff = 1'b1;
    repeat (2) tick();
    update_req = 1'b1; relock_req = 1'b1; tick();
    update_req = 1'b0; relock_req = 1'b0;
    checks++;
    if ({pd_n, upd, code_valid, ready} !== 4'b0000) begin
      failures++; $display("FAIL relock_wins got=%b exp=0000", {pd_n, upd, code_valid, ready});
    end
    wait_ready();
    n = 0;
    repeat (30) begin if (upd === 1'b1) n++; tick(); end
    checks++; if (n != 0) begin failures++; $display("FAIL pending_not_cleared got=%0d exp=0", n); end
    dll_delay_diff = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int n;
    logic prev;
    update_req = 1'b1; tick(); update_req = 1'b0;
    repeat (4) tick();
    update_req = 1'b1; tick();
    tick();
    update_req = 1'b0; tick();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL locked_before_extra got=%b exp=1", ready); end
    tick();
    checks++; if (upd !== 1'b1) begin failures++; $display("FAIL extra_update_start got=%b exp=1", upd); end
    n = 0; prev = 1'b1;
    repeat (40) begin tick(); if (upd === 1'b1 && prev === 1'b0) n++; prev = upd; end
    checks++; if (n != 0) begin failures++; $display("FAIL extra_update_count got=%0d exp=0", n); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_after_extra got=%b exp=1", ready); end
  endtask

  task automatic test_reset_abort();
    update_req = 1'b1; tick(); update_req = 1'b0;
    checks++; if (upd !== 1'b1) begin failures++; $display("FAIL abort_pulse_start got=%b exp=1", upd); end
    rst_n = 1'b0; tick();
    checks++;
    if ({pd_n, upd, code_q, code_valid, ready, lock_lost, timeout} !== 14'h0) begin
      failures++; $display("FAIL reset_abort got=%h exp=0",
        {pd_n, upd, code_q, code_valid, ready, lock_lost, timeout});
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_update_req();
    test_filter_glitch();
    test_lock_loss();
    test_simultaneous();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
